// File: rtl/data_rx_if.sv
// FIFO-side and payload-side signals of the link receiver, bundled for data_rx.
// The master modport is the receiver; the slave modport is the FIFO/consumer side.
interface data_rx_if;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       local_sync;
    logic [7:0] data_out;
    logic       data_valid;
    logic       sync_lost;

    modport master (
        input  rx_empty, r_data,
        output rd_uart, local_sync, data_out, data_valid, sync_lost
    );

    modport slave (
        output rx_empty, r_data,
        input  rd_uart, local_sync, data_out, data_valid, sync_lost
    );
endinterface

// File: rtl/data_rx.sv
// Link receiver: drains the UART RX FIFO, locks on a SYNC_BYTE preamble and delivers payload.
// Optional DATA_RX_STATS_EN adds sync_err_cnt (preamble breaks) and rx_byte_cnt (delivered bytes).
module data_rx #(
    parameter logic [7:0] SYNC_BYTE      = 8'hAA,
    parameter int          SYNC_COUNT     = 4,
    parameter int          TIMEOUT_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    data_rx_if.master    bus
`ifdef DATA_RX_STATS_EN
    ,
    output logic [7:0]   sync_err_cnt,
    output logic [15:0]  rx_byte_cnt
`endif
);

    localparam int              IDLE_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      CNT_LOCK = 4'(SYNC_COUNT);

    typedef enum logic [1:0] {
        HUNT       = 2'd0,
        COUNT      = 2'd1,
        LOCK_DRAIN = 2'd2,
        LOCK_DATA  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              local_sync_q, local_sync_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              sync_lost_q, sync_lost_d;

    logic pop;
    logic is_sync;

    // The FIFO is drained unconditionally so it can never back up behind a stalled FSM.
    assign pop           = !bus.rx_empty && rst_n;
    assign bus.rd_uart   = pop;
    assign is_sync       = (bus.r_data == SYNC_BYTE);

    assign bus.local_sync = local_sync_q;
    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.sync_lost  = sync_lost_q;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        idle_d       = idle_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        sync_lost_d  = 1'b0;

        unique case (state_q)
            HUNT: begin
                idle_d = '0;
                if (pop && is_sync) begin
                    cnt_d   = 4'd1;
                    state_d = (SYNC_COUNT == 1) ? LOCK_DRAIN : COUNT;
                end
            end
            COUNT: begin
                idle_d = '0;
                if (pop) begin
                    if (is_sync) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == CNT_LOCK) state_d = LOCK_DRAIN;
                    end else begin
                        cnt_d   = '0;
                        state_d = HUNT;
                    end
                end
            end
            LOCK_DRAIN, LOCK_DATA: begin
                if (pop) begin
                    idle_d = '0;
                    // Leading filler after lock is dropped; once payload starts every byte counts.
                    if (state_q == LOCK_DATA || !is_sync) begin
                        data_out_d   = bus.r_data;
                        data_valid_d = 1'b1;
                        state_d      = LOCK_DATA;
                    end
                end else if (idle_q == IDLE_MAX) begin
                    idle_d      = '0;
                    cnt_d       = '0;
                    sync_lost_d = 1'b1;
                    state_d     = HUNT;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            default: state_d = HUNT;
        endcase

        local_sync_d = (state_d == LOCK_DRAIN) || (state_d == LOCK_DATA);
    end

`ifdef DATA_RX_STATS_EN
    logic [7:0]  sync_err_q, sync_err_d;
    logic [15:0] rx_byte_q, rx_byte_d;

    always_comb begin
        sync_err_d = sync_err_q;
        if (state_q == COUNT && pop && !is_sync && sync_err_q != 8'hFF)
            sync_err_d = sync_err_q + 8'd1;
        rx_byte_d = data_valid_d ? rx_byte_q + 16'd1 : rx_byte_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err_q <= '0;
            rx_byte_q  <= '0;
        end else begin
            sync_err_q <= sync_err_d;
            rx_byte_q  <= rx_byte_d;
        end
    end

    assign sync_err_cnt = sync_err_q;
    assign rx_byte_cnt  = rx_byte_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            cnt_q        <= '0;
            idle_q       <= '0;
            local_sync_q <= 1'b0;
            data_out_q   <= 8'h00;
            data_valid_q <= 1'b0;
            sync_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idle_q       <= idle_d;
            local_sync_q <= local_sync_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            sync_lost_q  <= sync_lost_d;
        end
    end

endmodule

// File: tb/tb_data_rx.sv
// Directed bench for data_rx (SYNC_COUNT=4, TIMEOUT_CYCLES=8); stats ports checked when
// DATA_RX_STATS_EN is defined.
module tb_data_rx;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    data_rx_if bus();

`ifdef DATA_RX_STATS_EN
    logic [7:0]  sync_err_cnt;
    logic [15:0] rx_byte_cnt;
`endif

    data_rx #(
        .SYNC_BYTE      (8'hAA),
        .SYNC_COUNT     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus)
`ifdef DATA_RX_STATS_EN
        ,
        .sync_err_cnt (sync_err_cnt),
        .rx_byte_cnt  (rx_byte_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte, let it be popped, then sample 1 time unit after the edge.
    task automatic pop_byte(input logic [7:0] b);
        bus.rx_empty = 1'b0;
        bus.r_data   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rx_empty = 1'b1;
        bus.r_data   = 8'hFF;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.rx_empty = 1'b1;
        bus.r_data   = 8'h00;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] tog_bytes [4];
        tog_bytes = '{8'h10, 8'h20, 8'h30, 8'h40};

        // Reset values, with rd_uart gated by reset even though data is present.
        rst_n        = 1'b0;
        bus.rx_empty = 1'b0;
        bus.r_data   = 8'hAA;
        @(posedge clk); #1;
        check("rst_rd_uart", bus.rd_uart, 0);
        check("rst_local_sync", bus.local_sync, 0);
        check("rst_data_out", bus.data_out, 8'h00);
        check("rst_data_valid", bus.data_valid, 0);
        check("rst_sync_lost", bus.sync_lost, 0);
        bus.rx_empty = 1'b1;
        #3 rst_n = 1'b1;

        // Lock on four AA, drain filler, deliver 12, AA, 34 back to back.
        for (int i = 0; i < 3; i++) begin
            pop_byte(8'hAA);
            check("t1_pre_lock_sync", bus.local_sync, 0);
        end
        check("t1_rd_uart_hi", bus.rd_uart, 1);
        pop_byte(8'hAA);
        check("t1_lock_sync", bus.local_sync, 1);
        check("t1_lock_dv", bus.data_valid, 0);
        pop_byte(8'hAA);
        check("t1_filler5_dv", bus.data_valid, 0);
        pop_byte(8'hAA);
        check("t1_filler6_dv", bus.data_valid, 0);
        pop_byte(8'h12);
        check("t1_p12_dv", bus.data_valid, 1);
        check("t1_p12_data", bus.data_out, 8'h12);
        pop_byte(8'hAA);
        check("t1_pAA_dv", bus.data_valid, 1);
        check("t1_pAA_data", bus.data_out, 8'hAA);
        pop_byte(8'h34);
        check("t1_p34_dv", bus.data_valid, 1);
        check("t1_p34_data", bus.data_out, 8'h34);

        // Timeout: sync_lost on the 8th idle edge after the last pop.
        for (int i = 1; i <= 7; i++) begin
            idle();
            check("to_idle_lost", bus.sync_lost, 0);
            check("to_idle_sync", bus.local_sync, 1);
        end
        check("to_hold_data", bus.data_out, 8'h34);
        check("to_hold_dv", bus.data_valid, 0);
        idle();
        check("to_lost_pulse", bus.sync_lost, 1);
        check("to_lost_sync", bus.local_sync, 0);
        idle();
        check("to_lost_once", bus.sync_lost, 0);
        pop_byte(8'hAA);
        check("to_hunt_aa_dv", bus.data_valid, 0);
        pop_byte(8'h7E);
        check("to_hunt_7e_dv", bus.data_valid, 0);
        check("to_hunt_sync", bus.local_sync, 0);

        // Preamble break: 55 restarts the count.
        do_reset();
        pop_byte(8'hAA);
        pop_byte(8'hAA);
        pop_byte(8'h55);
        check("t2_break_sync", bus.local_sync, 0);
        for (int i = 0; i < 3; i++) begin
            pop_byte(8'hAA);
            check("t2_recount_sync", bus.local_sync, 0);
        end
        pop_byte(8'hAA);
        check("t2_lock_sync", bus.local_sync, 1);
        pop_byte(8'h01);
        check("t2_p01_dv", bus.data_valid, 1);
        check("t2_p01_data", bus.data_out, 8'h01);
`ifdef DATA_RX_STATS_EN
        check("t2_sync_err_cnt", sync_err_cnt, 1);
        check("t2_rx_byte_cnt", rx_byte_cnt, 1);
`endif

        // Pop arriving on the timeout cycle wins.
        for (int i = 1; i <= 7; i++) idle();
        check("t4_pre_lost", bus.sync_lost, 0);
        pop_byte(8'h5A);
        check("t4_no_lost", bus.sync_lost, 0);
        check("t4_dv", bus.data_valid, 1);
        check("t4_data", bus.data_out, 8'h5A);
        check("t4_sync", bus.local_sync, 1);
        idle();
        check("t4_after_lost", bus.sync_lost, 0);
        check("t4_after_sync", bus.local_sync, 1);

        // rx_empty toggling: rd_uart tracks it, one pulse per pop.
        foreach (tog_bytes[i]) begin
            bus.rx_empty = 1'b0;
            bus.r_data   = tog_bytes[i];
            #1 check("tg_rd_hi", bus.rd_uart, 1);
            @(posedge clk); #1;
            check("tg_dv_hi", bus.data_valid, 1);
            check("tg_data", bus.data_out, {8'h00, tog_bytes[i]});
            bus.rx_empty = 1'b1;
            bus.r_data   = 8'hFF;
            #1 check("tg_rd_lo", bus.rd_uart, 0);
            @(posedge clk); #1;
            check("tg_dv_lo", bus.data_valid, 0);
        end
`ifdef DATA_RX_STATS_EN
        check("tg_rx_byte_cnt", rx_byte_cnt, 6);
`endif

        // Asynchronous reset mid-cycle while locked with a payload pulse active.
        pop_byte(8'h66);
        check("ar_pre_dv", bus.data_valid, 1);
        #2 rst_n = 1'b0;
        bus.rx_empty = 1'b1;
        #1;
        check("ar_sync", bus.local_sync, 0);
        check("ar_dv", bus.data_valid, 0);
        check("ar_lost", bus.sync_lost, 0);
        check("ar_data", bus.data_out, 8'h00);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pop_byte(8'hAA);
            check("ar_relock_pre", bus.local_sync, 0);
        end
        pop_byte(8'hAA);
        check("ar_relock", bus.local_sync, 1);
        pop_byte(8'h99);
        check("ar_p99_dv", bus.data_valid, 1);
        check("ar_p99_data", bus.data_out, 8'h99);
`ifdef DATA_RX_STATS_EN
        check("ar_rx_byte_cnt", rx_byte_cnt, 1);
        check("ar_sync_err_cnt", sync_err_cnt, 0);
`endif
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_rx.md
Name: data_rx

Overview:
- Receive-side counterpart of the link's byte transmitter.
- Drains the UART RX FIFO and hunts for the 0xAA sync preamble sent by the peer.
- Asserts local_sync once the preamble is confirmed; this feeds the local transmitter's local_sync input so that both ends switch to payload together.
- After lock, strips trailing preamble filler and delivers payload bytes as single-cycle valid pulses; drops lock on an idle timeout.

Parameters:
- SYNC_BYTE, 8'hAA, preamble byte value.
- SYNC_COUNT, 4, consecutive SYNC_BYTEs required to lock; legal range 1..15.
- TIMEOUT_CYCLES, 1_000_000, idle clk cycles with no byte popped while locked before lock is dropped; legal range ≥2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_empty  in  1  UART RX FIFO empty flag
- r_data  in  8  UART RX FIFO head byte (show-ahead; valid whenever rx_empty=0)
- rd_uart  out  1  FIFO pop strobe; byte is consumed on the clk edge where rd_uart=1
- local_sync  out  1  link locked; level signal
- data_out  out  8  payload byte
- data_valid  out  1  one-cycle strobe qualifying data_out
- sync_lost  out  1  one-cycle strobe when lock is dropped by timeout

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - State HUNT; sync counter 0; idle counter 0.
  - Outputs: local_sync=0, data_out=8'h00, data_valid=0, sync_lost=0.
- rd_uart is combinational: rd_uart = !rx_empty && rst_n. The FIFO is drained in every state, so it never backs up. A "pop" below means a clk edge with rd_uart=1, and the popped byte is r_data at that edge.
- All other outputs are registered.
- FSM states:
  - HUNT: pop of SYNC_BYTE → cnt=1; next state is LOCK_DRAIN if SYNC_COUNT==1, else COUNT. Any other byte is discarded and the FSM stays in HUNT.
  - COUNT: pop of SYNC_BYTE → cnt+1; when cnt+1==SYNC_COUNT → LOCK_DRAIN. Pop of any other byte → HUNT, cnt=0. The offending byte is discarded and not re-examined.
  - LOCK_DRAIN: local_sync=1. Pops of SYNC_BYTE are discarded as filler. The first non-SYNC byte is delivered as payload, then the FSM goes to LOCK_DATA.
  - LOCK_DATA: local_sync=1. Every popped byte, including SYNC_BYTE values, is delivered as payload.
- local_sync rises on the cycle after the pop that completes the count.
- Delivery: data_out=popped byte and data_valid=1 on the cycle after the pop (latency 1). data_out holds its last value when data_valid=0.
- Back-to-back pops give back-to-back data_valid pulses; throughput is 1 byte/clk.
- Idle timeout (LOCK_DRAIN and LOCK_DATA only):
  - The idle counter clears on each pop and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 with no pop in that cycle: next state HUNT, local_sync=0 next cycle, sync_lost=1 for one cycle, cnt=0.
  - If a pop coincides with the timeout cycle, the pop wins: the byte is delivered, the counter clears and lock is held.
  - The counter is held at 0 in HUNT and COUNT.
  - The counter is sized $clog2(TIMEOUT_CYCLES) bits and never wraps.
- Reset mid-operation: immediate return to the reset values above. Any partially counted preamble is lost. A pop in flight is not delivered.
- rx_empty=1 in any state: no pop and no state change, apart from the idle counter in the locked states.

Optional Feature:
- Macro: DATA_RX_STATS_EN
- Defined:
  - Adds port sync_err_cnt (out, 8): a saturating count of preamble breaks, i.e. non-SYNC bytes popped in COUNT.
  - Adds port rx_byte_cnt (out, 16): a wrapping count of data_valid pulses.
  - Both counters reset to 0 on rst_n and are unaffected by timeout.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- SYNC_COUNT=4. Feed AA,AA,AA,AA,AA,AA,12,AA,34 with rx_empty=0 throughout → local_sync rises the cycle after the 4th pop. The 5th and 6th AA produce no data_valid. data_valid pulses carry 12, AA, 34 on consecutive cycles, each 1 cycle after its pop.
- Feed AA,AA,55,AA,AA,AA,AA,01 → 55 resets the count and local_sync stays 0. Lock follows the next four AA. 01 is delivered. With DATA_RX_STATS_EN: sync_err_cnt=1 and rx_byte_cnt=1.
- TIMEOUT_CYCLES=8, locked, rx_empty held 1 → sync_lost pulses exactly once, 8 cycles after the last pop, and local_sync=0 from the same cycle. A following AA,7E shows no data_valid (back in HUNT).
- TIMEOUT_CYCLES=8, locked, pop presented on the 8th idle cycle → no sync_lost, byte delivered, lock held.
- Locked in LOCK_DATA, assert rst_n=0 asynchronously mid-cycle → local_sync, data_valid and sync_lost go to 0 immediately without a clk edge. After release, HUNT requires 4 fresh AA bytes to relock.
- rx_empty toggled every other cycle during lock → rd_uart follows !rx_empty exactly. One data_valid per pop, no duplicates, no drops.
